box_renderer: RTL and testbench

//   Pixel-sweep engine directly downstream of the game state controller.

---
 rtl/box_renderer.sv | 183 ++++++++++++++++++
 tb/tb_box_renderer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/box_renderer.sv
// Box rasteriser: sweeps a BOX_W x BOX_H box into the framebuffer write port,
// one pixel per clock in raster order, clipping pixels that fall off screen.
`timescale 1ns/1ps
module box_renderer #(
    parameter int X_WIDTH      = 8,
    parameter int Y_WIDTH      = 7,
    parameter int COLOUR_WIDTH = 3,
    parameter int BOX_W        = 4,
    parameter int BOX_H        = 4,
    parameter int SCREEN_W     = 160,
    parameter int SCREEN_H     = 120
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    draw_box,
    input  logic                    erase_box,
    input  logic [X_WIDTH-1:0]      box_x,
    input  logic [Y_WIDTH-1:0]      box_y,
    input  logic [COLOUR_WIDTH-1:0] box_colour,
    input  logic [COLOUR_WIDTH-1:0] bg_colour,
    output logic                    busy,
    output logic                    done,
    output logic [X_WIDTH-1:0]      vga_x,
    output logic [Y_WIDTH-1:0]      vga_y,
    output logic [COLOUR_WIDTH-1:0] vga_colour,
    output logic                    vga_plot
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLOT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [X_WIDTH-1:0] COL_LAST     = X_WIDTH'(BOX_W - 1);
    localparam logic [Y_WIDTH-1:0] ROW_LAST     = Y_WIDTH'(BOX_H - 1);
    localparam logic [X_WIDTH:0]   SCREEN_X_LIM = (X_WIDTH + 1)'(SCREEN_W);
    localparam logic [Y_WIDTH:0]   SCREEN_Y_LIM = (Y_WIDTH + 1)'(SCREEN_H);

    state_t                    state_r;
    state_t                    state_s;
    logic [X_WIDTH-1:0]        bx_r;
    logic [Y_WIDTH-1:0]        by_r;
    logic [COLOUR_WIDTH-1:0]   colour_r;
    logic [X_WIDTH-1:0]        col_r;
    logic [Y_WIDTH-1:0]        row_r;

    logic                      req_s;
    logic                      last_col_s;
    logic                      last_row_s;
    logic [X_WIDTH:0]          sum_x_s;
    logic [Y_WIDTH:0]          sum_y_s;
    logic                      clip_s;

    logic                      busy_s;
    logic                      done_s;
    logic                      plot_s;
    logic [X_WIDTH-1:0]        x_s;
    logic [Y_WIDTH-1:0]        y_s;
    logic [COLOUR_WIDTH-1:0]   colour_s;

    assign req_s      = draw_box | erase_box;
    assign last_col_s = (col_r == COL_LAST);
    assign last_row_s = (row_r == ROW_LAST);
    // One extra bit so boxes hanging off the right/bottom edge are detected, not wrapped.
    assign sum_x_s    = {1'b0, bx_r} + {1'b0, col_r};
    assign sum_y_s    = {1'b0, by_r} + {1'b0, row_r};
    assign clip_s     = (sum_x_s >= SCREEN_X_LIM) || (sum_y_s >= SCREEN_Y_LIM);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_s) begin
                    state_s = S_LOAD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: state_s = S_PLOT;
            S_PLOT: begin
                if (last_col_s && last_row_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_PLOT;
                end
            end
            S_DONE: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Request latching and sweep counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            bx_r     <= {X_WIDTH{1'b0}};
            by_r     <= {Y_WIDTH{1'b0}};
            colour_r <= {COLOUR_WIDTH{1'b0}};
            col_r    <= {X_WIDTH{1'b0}};
            row_r    <= {Y_WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_s) begin
                        bx_r     <= box_x;
                        by_r     <= box_y;
                        colour_r <= erase_box ? bg_colour : box_colour;
                    end
                end
                S_LOAD: begin
                    col_r <= {X_WIDTH{1'b0}};
                    row_r <= {Y_WIDTH{1'b0}};
                end
                S_PLOT: begin
                    if (last_col_s) begin
                        col_r <= {X_WIDTH{1'b0}};
                        row_r <= row_r + Y_WIDTH'(1);
                    end else begin
                        col_r <= col_r + X_WIDTH'(1);
                    end
                end
                default: begin
                    col_r <= col_r;
                    row_r <= row_r;
                end
            endcase
        end
    end

    // Output decode; busy covers the accept edge through the final pixel.
    always_comb begin
        busy_s   = 1'b0;
        done_s   = 1'b0;
        plot_s   = 1'b0;
        x_s      = vga_x;
        y_s      = vga_y;
        colour_s = vga_colour;
        case (state_r)
            S_IDLE: busy_s = req_s;
            S_LOAD: busy_s = 1'b1;
            S_PLOT: begin
                busy_s   = 1'b1;
                plot_s   = ~clip_s;
                x_s      = sum_x_s[X_WIDTH-1:0];
                y_s      = sum_y_s[Y_WIDTH-1:0];
                colour_s = colour_r;
            end
            S_DONE: done_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= {X_WIDTH{1'b0}};
            vga_y      <= {Y_WIDTH{1'b0}};
            vga_colour <= {COLOUR_WIDTH{1'b0}};
        end else begin
            busy       <= busy_s;
            done       <= done_s;
            vga_plot   <= plot_s;
            vga_x      <= x_s;
            vga_y      <= y_s;
            vga_colour <= colour_s;
        end
    end

endmodule

// File: tb/tb_box_renderer.sv
// Scoreboard bench for box_renderer: stimulus queues expected pixels and done
// cycles; a negedge monitor pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_box_renderer;

    logic       clock = 1'b0;
    logic       reset;
    logic       draw_box, erase_box;
    logic [7:0] box_x;
    logic [6:0] box_y;
    logic [2:0] box_colour, bg_colour;
    logic       busy, done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t exp_pix[$];
    int   exp_done[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    box_renderer dut (
        .clock(clock), .reset(reset), .draw_box(draw_box), .erase_box(erase_box),
        .box_x(box_x), .box_y(box_y), .box_colour(box_colour), .bg_colour(bg_colour),
        .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected pixels of one sweep accepted at edge acc, clipped ones omitted.
    task automatic push_sweep(input int x, input int y, input int col, input int acc);
        pix_t p;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if ((x + c) < 160 && (y + r) < 120) begin
                    p.x = x + c;
                    p.y = y + r;
                    p.c = col;
                    exp_pix.push_back(p);
                end
            end
        end
        exp_done.push_back(acc + 18);
    endtask

    // Issue a one-cycle request; returns the accept edge number.
    task automatic start(input bit drw, input bit ers, input int x, input int y,
                         input logic [2:0] fg, input logic [2:0] bg, output int acc);
        @(negedge clock);
        draw_box   = drw;
        erase_box  = ers;
        box_x      = x[7:0];
        box_y      = y[6:0];
        box_colour = fg;
        bg_colour  = bg;
        acc        = cyc + 1;
        push_sweep(x, y, ers ? int'(bg) : int'(fg), acc);
        @(negedge clock);
        chk("busy_after_accept", int'(busy), 1);
        chk("plot_in_load", int'(vga_plot), 0);
        draw_box  = 1'b0;
        erase_box = 1'b0;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 100 && (exp_pix.size() != 0 || exp_done.size() != 0); i++) begin
            @(negedge clock);
        end
        chk("drain_left", exp_pix.size() + exp_done.size(), 0);
        repeat (4) @(negedge clock);
    endtask

    // Monitor: every plot and every done pulse must match the head of its queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (vga_plot) begin
                if (exp_pix.size() == 0) begin
                    chk("unexpected_plot", 1, 0);
                end else begin
                    pix_t p;
                    p = exp_pix.pop_front();
                    chk("pix_x", int'(vga_x), p.x);
                    chk("pix_y", int'(vga_y), p.y);
                    chk("pix_colour", int'(vga_colour), p.c);
                end
            end
            if (done) begin
                chk("busy_with_done", int'(busy), 0);
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("done_cycle", cyc, exp_done.pop_front());
                end
            end
        end
    end

    initial begin
        int acc;
        reset      = 1'b1;
        draw_box   = 1'b0;
        erase_box  = 1'b0;
        box_x      = 8'd0;
        box_y      = 7'd0;
        box_colour = 3'd0;
        bg_colour  = 3'd0;
        repeat (3) @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_x", int'(vga_x), 0);
        chk("rst_y", int'(vga_y), 0);
        chk("rst_colour", int'(vga_colour), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Plain draw.
        start(1'b1, 1'b0, 10, 20, 3'b100, 3'b010, acc);
        wait_drain();

        // Erase wins over draw.
        start(1'b1, 1'b1, 30, 40, 3'b111, 3'b000, acc);
        wait_drain();

        // Bottom-right corner clipping.
        start(1'b1, 1'b0, 158, 118, 3'b011, 3'b000, acc);
        wait_drain();

        // Inputs changed and a stray request issued mid-sweep.
        start(1'b1, 1'b0, 50, 60, 3'b101, 3'b000, acc);
        repeat (4) @(negedge clock);
        box_x      = 8'd5;
        box_colour = 3'b010;
        draw_box   = 1'b1;
        @(negedge clock);
        draw_box   = 1'b0;
        wait_drain();

        // Request held high: second sweep accepted right after the done cycle.
        @(negedge clock);
        draw_box   = 1'b1;
        box_x      = 8'd70;
        box_y      = 7'd80;
        box_colour = 3'b110;
        acc        = cyc + 1;
        push_sweep(70, 80, 6, acc);
        push_sweep(70, 80, 6, acc + 19);
        for (int i = 0; i < 40 && cyc < acc + 18; i++) @(negedge clock);
        chk("b2b_busy_in_done", int'(busy), 0);
        @(negedge clock);
        chk("b2b_busy_reaccept", int'(busy), 1);
        draw_box = 1'b0;
        wait_drain();

        // Reset in the middle of a sweep.
        start(1'b1, 1'b0, 90, 90, 3'b001, 3'b000, acc);
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_plot", int'(vga_plot), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_x", int'(vga_x), 0);
        exp_pix.delete();
        exp_done.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        chk("midrst_busy_after", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
